// File: rtl/ulpi_reg_write_pkg.sv
// Shared ULPI definitions: TX CMD prefixes, PHY register addresses and the
// register-write FSM state encoding.
package ulpi_reg_write_pkg;

  localparam logic [1:0] TXCMD_REGW = 2'b10;
  localparam logic [1:0] TXCMD_REGR = 2'b11;
  localparam logic [7:0] ULPI_NOOP  = 8'h00;

  // USB3320 immediate register addresses (write offsets)
  localparam logic [5:0] REG_FUNC_CTRL = 6'h04;
  localparam logic [5:0] REG_IFC_CTRL  = 6'h07;
  localparam logic [5:0] REG_OTG_CTRL  = 6'h0A;
  localparam logic [5:0] REG_SCRATCH   = 6'h16;
  localparam logic [5:0] REG_EXT_ADDR  = 6'h2F;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_TXCMD,
    WR_DATA,
    WR_STOP,
    WR_ABORT,
    WR_TURN,
    WR_RELEASE
  } wr_state_e;

  function automatic logic [7:0] regw_cmd(input logic [5:0] addr);
    return {TXCMD_REGW, addr};
  endfunction

endpackage

// File: rtl/ulpi_reg_write.sv
// ULPI link-side register write: TX CMD REGW, data byte, STP, with full resend
// whenever the PHY turns the bus around mid-transfer.
module ulpi_reg_write
  import ulpi_reg_write_pkg::*;
#(
  parameter int MAX_RETRIES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] reg_write_addr,
  input  logic [7:0] reg_write_data,
  input  logic       reg_write_en,
  output logic       reg_write_done,
  output logic       reg_write_error,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic       ulpi_stp,
  output logic [7:0] ulpi_data_out,
  output logic       ulpi_data_oe
);

  localparam int RW = $clog2(MAX_RETRIES + 1);

  wr_state_e       r_state;
  logic [RW-1:0]   r_retry;
  logic [5:0]      r_addr;
  logic [7:0]      r_wdata;
  logic [7:0]      r_data_out;
  logic            r_drive;
  logic            r_stp;
  logic            r_done;
  logic            r_error;

  logic [RW-1:0]   w_retry_inc;
  logic            w_retry_last;

  assign w_retry_inc  = r_retry + RW'(1);
  assign w_retry_last = (w_retry_inc == RW'(MAX_RETRIES));

  // Gate on live dir so the link lets go in the same cycle the PHY takes the bus
  assign ulpi_data_oe    = r_drive & ~ulpi_dir;
  assign ulpi_data_out   = r_data_out;
  assign ulpi_stp        = r_stp;
  assign reg_write_done  = r_done;
  assign reg_write_error = r_error;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= WR_IDLE;
      r_retry    <= '0;
      r_data_out <= ULPI_NOOP;
      r_drive    <= 1'b0;
      r_stp      <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_stp   <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        WR_IDLE: begin
          if (reg_write_en && !ulpi_dir) begin
            r_addr     <= reg_write_addr;
            r_wdata    <= reg_write_data;
            r_retry    <= '0;
            r_data_out <= regw_cmd(reg_write_addr);
            r_drive    <= 1'b1;
            r_state    <= WR_TXCMD;
          end
        end
        WR_TXCMD: begin
          if (ulpi_dir) begin
            r_data_out <= ULPI_NOOP;
            r_drive    <= 1'b0;
            r_state    <= WR_ABORT;
          end else if (ulpi_nxt) begin
            r_data_out <= r_wdata;
            r_state    <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (ulpi_dir) begin
            r_data_out <= ULPI_NOOP;
            r_drive    <= 1'b0;
            r_state    <= WR_ABORT;
          end else if (ulpi_nxt) begin
            r_data_out <= ULPI_NOOP;
            r_stp      <= 1'b1;
            r_state    <= WR_STOP;
          end
        end
        // Data byte already accepted, so dir here cannot undo the write
        WR_STOP: begin
          r_drive <= 1'b0;
          r_done  <= 1'b1;
          r_state <= WR_RELEASE;
        end
        WR_ABORT: begin
          if (!ulpi_dir) begin
            r_state <= WR_TURN;
          end
        end
        WR_TURN: begin
          r_retry <= w_retry_inc;
          if (w_retry_last) begin
            r_error <= 1'b1;
            r_state <= WR_RELEASE;
          end else begin
            r_data_out <= regw_cmd(r_addr);
            r_drive    <= 1'b1;
            r_state    <= WR_TXCMD;
          end
        end
        WR_RELEASE: begin
          if (!reg_write_en) begin
            r_state <= WR_IDLE;
          end
        end
        default: begin
          r_data_out <= ULPI_NOOP;
          r_drive    <= 1'b0;
          r_state    <= WR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ulpi_reg_write.sv
// Directed bench for ulpi_reg_write: normal write, nxt throttling, dir aborts,
// retry exhaustion, level-enable handling and mid-transfer reset.
module tb_ulpi_reg_write;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] reg_write_addr;
  logic [7:0] reg_write_data;
  logic       reg_write_en;
  logic       reg_write_done;
  logic       reg_write_error;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic       ulpi_stp;
  logic [7:0] ulpi_data_out;
  logic       ulpi_data_oe;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ulpi_reg_write #(.MAX_RETRIES(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .reg_write_addr  (reg_write_addr),
    .reg_write_data  (reg_write_data),
    .reg_write_en    (reg_write_en),
    .reg_write_done  (reg_write_done),
    .reg_write_error (reg_write_error),
    .ulpi_dir        (ulpi_dir),
    .ulpi_nxt        (ulpi_nxt),
    .ulpi_stp        (ulpi_stp),
    .ulpi_data_out   (ulpi_data_out),
    .ulpi_data_oe    (ulpi_data_oe)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expo(input string tag, input logic [7:0] d, input logic oe,
                      input logic stp, input logic dn, input logic er);
    chk({tag, "/data"},  ulpi_data_out,       d);
    chk({tag, "/oe"},    8'(ulpi_data_oe),    8'(oe));
    chk({tag, "/stp"},   8'(ulpi_stp),        8'(stp));
    chk({tag, "/done"},  8'(reg_write_done),  8'(dn));
    chk({tag, "/error"}, 8'(reg_write_error), 8'(er));
  endtask

  initial begin
    rst_n          = 1'b0;
    reg_write_en   = 1'b0;
    reg_write_addr = 6'h0A;
    reg_write_data = 8'h55;
    ulpi_dir       = 1'b0;
    ulpi_nxt       = 1'b0;
    cyc();
    cyc();
    expo("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc();
    expo("idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // 1: basic write, inputs changed after latch
    reg_write_en = 1'b1;
    ulpi_nxt     = 1'b1;
    cyc();
    expo("t1_txcmd", 8'h8A, 1'b1, 1'b0, 1'b0, 1'b0);
    reg_write_addr = 6'h3F;
    reg_write_data = 8'hFF;
    cyc();
    expo("t1_data", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    expo("t1_stop", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    expo("t1_done", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    reg_write_en = 1'b0;
    cyc();
    expo("t1_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: nxt low three edges in TXCMD
    reg_write_addr = 6'h16;
    reg_write_data = 8'hA5;
    reg_write_en   = 1'b1;
    ulpi_nxt       = 1'b0;
    cyc();
    expo("t2_txcmd0", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      expo("t2_hold", 8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    ulpi_nxt = 1'b1;
    cyc();
    expo("t2_data", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    expo("t2_stop", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    expo("t2_done", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    reg_write_en = 1'b0;
    cyc();
    expo("t2_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3: dir rises in DATA for two edges, then resend
    reg_write_addr = 6'h0A;
    reg_write_data = 8'h55;
    reg_write_en   = 1'b1;
    cyc();
    expo("t3_txcmd", 8'h8A, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    expo("t3_data", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    ulpi_dir = 1'b1;
    #1;
    chk("t3_oe_comb", 8'(ulpi_data_oe), 8'h00);
    cyc();
    expo("t3_abort0", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    expo("t3_abort1", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    ulpi_dir = 1'b0;
    cyc();
    expo("t3_turn", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    expo("t3_retx", 8'h8A, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    expo("t3_redata", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    expo("t3_stop", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    expo("t3_done", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    reg_write_en = 1'b0;
    cyc();
    expo("t3_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // 4: dir on every attempt exhausts retries
    ulpi_nxt     = 1'b0;
    reg_write_en = 1'b1;
    cyc();
    expo("t4_txcmd", 8'h8A, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ulpi_dir = 1'b1;
      cyc();
      expo("t4_abort", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      ulpi_dir = 1'b0;
      cyc();
      expo("t4_turn", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc();
      if (i < 2) expo("t4_resend", 8'h8A, 1'b1, 1'b0, 1'b0, 1'b0);
      else       expo("t4_error", 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    cyc();
    expo("t4_after", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reg_write_en = 1'b0;
    ulpi_nxt     = 1'b1;
    cyc();
    expo("t4_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // 5: dir in STOP, then en held high after done
    reg_write_en = 1'b1;
    cyc();
    expo("t5_txcmd", 8'h8A, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    expo("t5_data", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    ulpi_dir = 1'b1;
    #1;
    expo("t5_stop_dir", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    expo("t5_done", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    ulpi_dir = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      expo("t5_hold", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reg_write_en = 1'b0;
    cyc();
    expo("t5_low", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    reg_write_addr = 6'h2F;
    reg_write_data = 8'h01;
    reg_write_en   = 1'b1;
    cyc();
    expo("t5_ext_txcmd", 8'hAF, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    expo("t5_ext_data", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    expo("t5_ext_stop", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    expo("t5_ext_done", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    reg_write_en = 1'b0;
    cyc();

    // 6: reset during DATA, then dir blocks start until it drops
    reg_write_addr = 6'h0A;
    reg_write_data = 8'h55;
    reg_write_en   = 1'b1;
    cyc();
    expo("t6_txcmd", 8'h8A, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    expo("t6_data", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    cyc();
    expo("t6_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n    = 1'b1;
    ulpi_dir = 1'b1;
    cyc();
    expo("t6_dir_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    ulpi_dir = 1'b0;
    cyc();
    expo("t6_fresh_txcmd", 8'h8A, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    expo("t6_data2", 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc();
    expo("t6_stop", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc();
    expo("t6_done", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    reg_write_en = 1'b0;
    cyc();
    expo("t6_idle", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
